// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: copy-engine state encoding and AXI constants.
package dmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RDATA,
    S_WREQ,
    S_WDATA,
    S_WRESP
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam int unsigned MAX_BURST_BEATS = 16;

endpackage

// File: rtl/axi_beat_buf.sv
// Burst staging buffer: read beats land at wr_ptr, write beats leave from rd_ptr.
module axi_beat_buf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic                  wr_ptr_clr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_inc_i,
  input  logic                  rd_ptr_clr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [3:0]            wr_ptr_o,
  output logic [3:0]            rd_ptr_o
);
  import dmac_pkg::*;

  logic [DATA_WIDTH-1:0] mem_q [MAX_BURST_BEATS];
  logic [DATA_WIDTH-1:0] mem_d [MAX_BURST_BEATS];
  logic [3:0]            wr_ptr_q, wr_ptr_d;
  logic [3:0]            rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) mem_d[wr_ptr_q] = wr_data_i;
    wr_ptr_d = wr_ptr_q;
    if (wr_ptr_clr_i)  wr_ptr_d = '0;
    else if (wr_en_i)  wr_ptr_d = wr_ptr_q + 4'd1;
    rd_ptr_d = rd_ptr_q;
    if (rd_ptr_clr_i)  rd_ptr_d = '0;
    else if (rd_inc_i) rd_ptr_d = rd_ptr_q + 4'd1;
  end

  // Storage needs no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/axi_copy_master.sv
// AXI4 copy engine: alternates one INCR read burst and one INCR write burst
// (up to 16 beats each) until the requested byte count has been moved.
module axi_copy_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [15:0]             byte_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    awvalid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  input  logic                    awready,
  output logic                    wvalid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    wready,
  output logic                    bready,
  input  logic                    bvalid,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  input  logic                    arready,
  output logic                    rready,
  input  logic                    rvalid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rlast,
  input  logic [1:0]              rresp
);
  import dmac_pkg::*;

  localparam int unsigned BPB    = DATA_WIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(BPB);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]           rem_q, rem_d;
  logic [3:0]            len_q, len_d;
  logic                  err_q, err_d, done_q, done_d;
  logic                  buf_wr, buf_wr_clr, buf_rd_inc, buf_rd_clr;
  logic [3:0]            wr_ptr, rd_ptr;
  logic [15:0]           chunk_bytes;
  logic                  unused_bid;

  // Burst length (beats-1) for the bytes still to move, capped at 16 beats.
  function automatic logic [3:0] chunk_len(input logic [15:0] bytes);
    logic [15:0] words;
    words = bytes >> BSHIFT;
    if (words == '0) return 4'd0;
    if (words >= 16'(MAX_BURST_BEATS)) return 4'd15;
    return words[3:0] - 4'd1;
  endfunction

  assign chunk_bytes = ({12'd0, len_q} + 16'd1) << BSHIFT;
  assign unused_bid  = ^bid;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    len_d      = len_q;
    err_d      = err_q;
    done_d     = 1'b0;
    buf_wr     = 1'b0;
    buf_wr_clr = 1'b0;
    buf_rd_inc = 1'b0;
    buf_rd_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = byte_len;
          len_d = chunk_len(byte_len);
          err_d = 1'b0;
          if (byte_len == '0) done_d  = 1'b1;
          else                state_d = S_RREQ;
        end
      end
      S_RREQ: begin
        if (arready) begin
          buf_wr_clr = 1'b1;
          state_d    = S_RDATA;
        end
      end
      S_RDATA: begin
        if (rvalid) begin
          buf_wr = 1'b1;
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast || wr_ptr == len_q) state_d = S_WREQ;
        end
      end
      S_WREQ: begin
        if (awready) begin
          buf_rd_clr = 1'b1;
          state_d    = S_WDATA;
        end
      end
      S_WDATA: begin
        if (wready) begin
          buf_rd_inc = 1'b1;
          if (rd_ptr == len_q) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          src_d = src_q + ADDR_WIDTH'(chunk_bytes);
          dst_d = dst_q + ADDR_WIDTH'(chunk_bytes);
          rem_d = rem_q - chunk_bytes;
          len_d = chunk_len(rem_d);
          if (rem_d == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RREQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  axi_beat_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_beat_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (buf_wr),
    .wr_ptr_clr_i(buf_wr_clr),
    .wr_data_i   (rdata),
    .rd_inc_i    (buf_rd_inc),
    .rd_ptr_clr_i(buf_rd_clr),
    .rd_data_o   (wdata),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr)
  );

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign arvalid = (state_q == S_RREQ);
  assign araddr  = src_q;
  assign arid    = ID_WIDTH'(AXI_ID);
  assign arlen   = {4'd0, len_q};
  assign arsize  = 3'(BSHIFT);
  assign arburst = AXI_BURST_INCR;
  assign rready  = (state_q == S_RDATA);
  assign awvalid = (state_q == S_WREQ);
  assign awaddr  = dst_q;
  assign awid    = ID_WIDTH'(AXI_ID);
  assign awlen   = {4'd0, len_q};
  assign awsize  = 3'(BSHIFT);
  assign awburst = AXI_BURST_INCR;
  assign wvalid  = (state_q == S_WDATA);
  assign wstrb   = '1;
  assign wlast   = wvalid && (rd_ptr == len_q);
  assign bready  = (state_q == S_WRESP);

endmodule

// File: doc/axi_copy_master.md
# axi_copy_master

AXI4 read/write master that copies a contiguous block of memory from a source to a destination address. It is the initiator side of the AW/W/B/AR/R channel interfaces, and the data-mover core of the DMAC. Software supplies src/dst/length through a one-cycle start pulse. The block moves data in INCR bursts of up to 16 beats through an internal 16-entry beat buffer: read burst first, then write burst, repeating until the length is exhausted.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of AR/AW addresses and src/dst inputs.
- DATA_WIDTH, `AXI_DATA_WIDTH (32), data bus width; bytes per beat BPB = DATA_WIDTH/8.
- ID_WIDTH, `AXI_ID_WIDTH, width of arid/awid.
- AXI_ID, 0, constant ID driven on arid/awid.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  command pulse; accepted only when busy=0.
- src_addr  input  ADDR_WIDTH  source byte address, BPB-aligned.
- dst_addr  input  ADDR_WIDTH  destination byte address, BPB-aligned.
- byte_len  input  16  transfer length in bytes, multiple of BPB.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at completion.
- err  output  1  sticky; set on any rresp/bresp ≠ 0; cleared on start acceptance.
- aw_ch  interface  AXI_AW_CH  master side: awvalid, awaddr, awid, awlen, awsize, awburst driven; awready sampled.
- w_ch  interface  AXI_W_CH  master side: wvalid, wdata, wstrb (all ones), wlast driven; wready sampled.
- b_ch  interface  AXI_B_CH  master side: bready driven; bvalid, bid, bresp sampled.
- ar_ch  interface  AXI_AR_CH  master side: arvalid, araddr, arid, arlen, arsize, arburst driven; arready sampled.
- r_ch  interface  AXI_R_CH  master side: rready driven; rvalid, rdata, rlast, rresp sampled.

## Operation
- Registers: src, dst (ADDR_WIDTH), remaining (16 b), len (4 b, current awlen/arlen), buf[16] × DATA_WIDTH, wptr/rptr (4 b), beat counter.
- Constant fields: arsize = awsize = log2(BPB) (2 for 32 b); arburst = awburst = INCR (2'b01); wstrb all ones.
- Chunk length: beats = min(remaining/BPB, 16); len = beats−1, computed on entry to S_RREQ.
- States:
  - S_IDLE: on start, latch inputs, clear err. If byte_len == 0, pulse done and stay in S_IDLE; otherwise go to S_RREQ.
  - S_RREQ: arvalid = 1, araddr = src. On arready, go to S_RDATA with wptr = 0.
  - S_RDATA: rready = 1. On each r handshake, buf[wptr] ← rdata and wptr++. On handshake with rlast (or the beats-th beat), go to S_WREQ.
  - S_WREQ: awvalid = 1, awaddr = dst. On awready, go to S_WDATA with rptr = 0.
  - S_WDATA: wvalid = 1, wdata = buf[rptr], wlast = (rptr == len). On wready, rptr++. After the handshake of the last beat, go to S_WRESP.
  - S_WRESP: bready = 1. On bvalid: src += beats·BPB, dst += beats·BPB, remaining −= beats·BPB. If the new remaining == 0, go to S_IDLE and pulse done; otherwise go to S_RREQ.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- No 4 KB boundary splitting; software guarantees ranges do not cross 4 KB.
- Error response: an rresp or bresp error sets err but does not abort the transfer.

## Timing
- Reset values: all valid/ready outputs 0, busy 0, done 0, err 0, state S_IDLE, addresses, counters and len 0.
- start is accepted on edge N; arvalid is high from edge N+1.
- arvalid/awvalid are held with stable address and len until the handshake, then drop on the next cycle.
- wvalid is held with stable wdata/wlast until wready.
- Exactly one outstanding transaction at a time; no AR while a write is pending, and no AW before the read burst completes.
- Per-beat throughput is 1 beat/cycle when the slave holds rvalid/wready high.
- done is asserted in the cycle after the final b handshake; busy falls in the same cycle.
- start while busy = 1 is ignored.
- Reset mid-transfer returns the block to S_IDLE immediately, with outputs at reset values; outstanding bus activity is abandoned.

## Structure
- Shared package dmac_pkg: state enum (S_IDLE … S_WRESP), AXI_BURST_INCR, AXI_SIZE_4B, MAX_BURST_BEATS = 16.
- Optional sub-module axi_beat_buf: 16 × DATA_WIDTH register file with a write port, a read port, and pointer-reset inputs.
- The FSM and address/length datapath stay in axi_copy_master.

## Test plan
- src = 0x0100, dst = 0x0800, len = 64 → one AR (arlen = 15), 16 R beats, one AW (awlen = 15), 16 W beats with wlast on beat 16; destination memory equals source; done 1 cycle after B.
- len = 72 → bursts of arlen = 15 then arlen = 1; the second AR address is 0x0140; all 72 bytes copied.
- len = 4 → arlen = awlen = 0, wlast asserted on the single beat.
- len = 0 → no AXI activity; done pulses the cycle after start; busy stays 0.
- Slave with ARREADY_DELAY = 3, AWREADY_DELAY = 2, and 50-cycle AR→R latency → arvalid/awvalid held stable until ready; data still correct.
- Reset asserted during S_WDATA → next cycle all valids 0 and busy 0; a new start of 16 bytes completes correctly; an injected bresp = 2 sets err, and the next start clears it.
